// File: rtl/seg_pkg.sv
// seg_pkg: shared types and helpers for the 7-segment scan controller.
//   slot_state_t : BLANK (dead time, all digits off) / DRIVE (one digit lit)
//   BLANK_CODE   : nibble the shared decoder maps to all segments off
//   lz_mask()    : leading-zero blank mask over a packed BCD value
package seg_pkg;

    typedef enum logic {BLANK, DRIVE} slot_state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Widest bank lz_mask() handles; callers zero-extend their value to this.
    localparam int MAX_DIGITS = 16;

    // Bit k set when nibbles k..n-1 are all zero and k != 0.
    // Digit 0 always stays lit so a zero value still shows "0".
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [4*MAX_DIGITS-1:0] shadow,
        input int                      n
    );
        logic run;
        lz_mask = '0;
        run     = 1'b1;
        for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
            if (k < n) begin
                run = run & (shadow[4*k +: 4] == 4'h0);
                if (k != 0) lz_mask[k] = run;
            end
        end
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// seg_slot_timer: slot cycle counter and digit index for the scan.
//   clk, rst_n : clock, asynchronous active-low reset
//   idx        : digit currently being scanned
//   in_blank   : slot is inside its dead time
//   slot_end   : last cycle of the current slot
//   frame_end  : last cycle of the last digit's slot
module seg_slot_timer
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 2,
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1,
    localparam int IW = $clog2(N_DIGITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [IW-1:0] idx,
    output logic          in_blank,
    output logic          slot_end,
    output logic          frame_end
);

    logic [CW-1:0] cnt;

    assign slot_end  = (cnt == CW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (idx == IW'(N_DIGITS - 1));

    // A zero dead time would make the compare constant-false; drop it instead.
    generate
        if (DEAD_CYC == 0) begin : g_no_dead
            assign in_blank = 1'b0;
        end else begin : g_dead
            assign in_blank = (cnt < CW'(DEAD_CYC));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= frame_end ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// 7-segment bank sharing one BCD decoder (decoder lives in the parent).
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : display value handshake (ready = pending empty)
//   in_data             : packed BCD, digit 0 in [3:0]
//   lz_blank            : leading-zero blanking, latched at frame boundary
//   digit_an            : active-low one-hot digit enable
//   bcd                 : nibble to the decoder, BLANK_CODE = dark
//   frame_done          : pulse on the last cycle of every frame
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*N_DIGITS-1:0] in_data,
    input  logic                  lz_blank,
    output logic [N_DIGITS-1:0]   digit_an,
    output logic [3:0]            bcd,
    output logic                  frame_done
);

    localparam int IW = $clog2(N_DIGITS);

    generate
        if (SCAN_DIV <= DEAD_CYC || N_DIGITS < 2 || N_DIGITS > MAX_DIGITS) begin : g_bad_cfg
            $error("seg_scan_ctrl: need SCAN_DIV > DEAD_CYC and 2 <= N_DIGITS <= MAX_DIGITS");
        end
    endgenerate

    logic [IW-1:0]         idx;
    logic                  in_blank;
    logic                  slot_end;
    logic                  frame_end;

    logic [4*N_DIGITS-1:0] shadow;
    logic [4*N_DIGITS-1:0] pend;
    logic                  pend_v;
    logic                  lz_q;
    logic                  accept;

    seg_slot_timer #(
        .N_DIGITS (N_DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .DEAD_CYC (DEAD_CYC)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (idx),
        .in_blank  (in_blank),
        .slot_end  (slot_end),
        .frame_end (frame_end)
    );

    assign in_ready = !pend_v;
    assign accept   = in_valid && in_ready;

    // Accepts always go to pend; shadow only changes at a frame boundary so
    // a frame is never torn between two values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '1;
            pend   <= '0;
            pend_v <= 1'b0;
            lz_q   <= 1'b0;
        end else begin
            if (frame_end) begin
                lz_q <= lz_blank;
                if (pend_v) shadow <= pend;
            end
            if (accept) begin
                pend   <= in_data;
                pend_v <= 1'b1;
            end else if (frame_end) begin
                pend_v <= 1'b0;
            end
        end
    end

    // Output decode, from registers only.
    logic [4*MAX_DIGITS-1:0] shadow_ext;
    logic [MAX_DIGITS-1:0]   lzm;
    logic [3:0]              nib;
    logic                    lz_hide;
    slot_state_t             state;

    always_comb begin
        shadow_ext                   = '0;
        shadow_ext[4*N_DIGITS-1:0]   = shadow;
    end

    assign lzm     = lz_mask(shadow_ext, N_DIGITS);
    assign nib     = shadow[4*idx +: 4];
    assign lz_hide = lz_q && lzm[idx];
    assign state   = in_blank ? BLANK : DRIVE;

    assign digit_an   = (state == BLANK) ? '1 : ~(N_DIGITS'(1) << idx);
    assign bcd        = (state == BLANK || lz_hide) ? BLANK_CODE : nib;
    assign frame_done = frame_end;

endmodule
